// File: rtl/hack_ram_dp.sv
`default_nettype none
// ============================================================================
// Module   : hack_ram_dp
// Purpose  : HACK data RAM, one R/W port (A) + one read port (B), registered
//            outputs, hardware zero-sweep after reset or on request.
// Revision : 1.0
// ============================================================================
module hack_ram_dp #(
    parameter int WIDTH       = 16,
    parameter int ADDR_WIDTH  = 13,
    parameter int WRITE_FIRST = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      data,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [WIDTH-1:0]      out,
    input  logic [ADDR_WIDTH-1:0] address_b,
    output logic [WIDTH-1:0]      out_b,
    input  logic                  clear,
    output logic                  ready
);

    localparam int                    c_depth = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_last  = '1;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic [WIDTH-1:0]        r_mem [c_depth];

    logic                    w_sweep;
    logic                    w_user_wr;
    logic                    w_we;
    logic [ADDR_WIDTH-1:0]   w_waddr;
    logic [WIDTH-1:0]        w_wdata;
    logic                    w_collide;
    logic [WIDTH-1:0]        w_rd_b;

    assign w_sweep   = (r_state == ST_CLEAR);
    assign w_user_wr = (r_state == ST_READY) && load && !clear;
    // Gated by rst so that holding reset never disturbs memory contents.
    assign w_we      = !rst && (w_sweep || w_user_wr);
    assign w_waddr   = w_sweep ? r_cnt : address;
    assign w_wdata   = w_sweep ? '0    : data;
    assign w_collide = load && (address_b == address);
    assign w_rd_b    = ((WRITE_FIRST != 0) && w_collide) ? data : r_mem[address_b];

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            out     <= '0;
            out_b   <= '0;
            ready   <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    out   <= '0;
                    out_b <= '0;
                    if (r_cnt == c_last) begin
                        r_state <= ST_READY;
                        r_cnt   <= '0;
                        ready   <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        ready   <= 1'b0;
                    end
                end
                ST_READY: begin
                    if (clear) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                        out     <= '0;
                        out_b   <= '0;
                        ready   <= 1'b0;
                    end else begin
                        out     <= r_mem[address];
                        out_b   <= w_rd_b;
                        ready   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_cnt   <= '0;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hack_ram_dp.sv
`default_nettype none
// ============================================================================
// Module   : tb_hack_ram_dp
// Purpose  : Scoreboard bench for hack_ram_dp, both WRITE_FIRST variants.
// Revision : 1.0
// ============================================================================
module tb_hack_ram_dp;

    localparam int W     = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        logic [W-1:0] out;
        logic [W-1:0] out_b0;
        logic [W-1:0] out_b1;
        logic         ready;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  data = '0;
    logic          load = 1'b0;
    logic [AW-1:0] address = '0;
    logic [AW-1:0] address_b = '0;
    logic          clear = 1'b0;

    logic [W-1:0]  out0, out_b0, out1, out_b1;
    logic          ready0, ready1;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t q[$];

    logic [W-1:0] m_mem [DEPTH];
    int           m_sweep = DEPTH;

    always #5 clk = ~clk;

    hack_ram_dp #(.WIDTH(W), .ADDR_WIDTH(AW), .WRITE_FIRST(0)) u_dut0 (
        .clk(clk), .rst(rst), .data(data), .load(load), .address(address),
        .out(out0), .address_b(address_b), .out_b(out_b0), .clear(clear), .ready(ready0)
    );

    hack_ram_dp #(.WIDTH(W), .ADDR_WIDTH(AW), .WRITE_FIRST(1)) u_dut1 (
        .clk(clk), .rst(rst), .data(data), .load(load), .address(address),
        .out(out1), .address_b(address_b), .out_b(out_b1), .clear(clear), .ready(ready1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: one call per rising edge, with the inputs seen at it.
    function automatic exp_t model_edge(logic r, logic ld, logic [AW-1:0] a,
                                        logic [AW-1:0] ab, logic [W-1:0] d, logic cl);
        exp_t e;
        e.out = '0; e.out_b0 = '0; e.out_b1 = '0; e.ready = 1'b0;
        if (r) begin
            m_sweep = DEPTH;
        end else if (m_sweep > 0) begin
            m_mem[DEPTH - m_sweep] = '0;
            m_sweep--;
            e.ready = (m_sweep == 0);
        end else if (cl) begin
            m_sweep = DEPTH;
        end else begin
            e.out    = m_mem[a];
            e.out_b0 = m_mem[ab];
            e.out_b1 = (ld && ab == a) ? d : m_mem[ab];
            e.ready  = 1'b1;
            if (ld) m_mem[a] = d;
        end
        return e;
    endfunction

    task automatic cyc(input logic r, input logic ld, input logic [AW-1:0] a,
                       input logic [AW-1:0] ab, input logic [W-1:0] d, input logic cl);
        @(negedge clk);
        rst = r; load = ld; address = a; address_b = ab; data = d; clear = cl;
        q.push_back(model_edge(r, ld, a, ab, d, cl));
        @(posedge clk);
    endtask

    // Monitor: every edge with an outstanding expectation is checked.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("ready0", {31'd0, ready0}, {31'd0, e.ready});
                chk("ready1", {31'd0, ready1}, {31'd0, e.ready});
                chk("out0",   {16'd0, out0},   {16'd0, e.out});
                chk("out1",   {16'd0, out1},   {16'd0, e.out});
                chk("out_b0", {16'd0, out_b0}, {16'd0, e.out_b0});
                chk("out_b1", {16'd0, out_b1}, {16'd0, e.out_b1});
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

        // Reset, then sweep with an attempted write to addr 3 and stray clears
        cyc(1, 1, 3, 3, 16'hBEEF, 0);
        cyc(1, 1, 3, 3, 16'hBEEF, 0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, 3, 3, 16'hBEEF, (i % 5) == 2);
        cyc(0, 0, 3, 3, 16'h0000, 0);

        // Basic read/write, untouched address
        cyc(0, 1, 5, 0, 16'h1234, 0);
        cyc(0, 0, 5, 5, 16'h0000, 0);
        cyc(0, 0, 6, 6, 16'h0000, 0);

        // Collisions on address 7
        cyc(0, 1, 7, 0, 16'h00AA, 0);
        cyc(0, 1, 7, 7, 16'h0055, 0);
        cyc(0, 0, 7, 7, 16'h0000, 0);

        // Clear request with simultaneous load, clear pulses mid-sweep
        cyc(0, 1, 2, 0, 16'hFFFF, 0);
        cyc(0, 1, 9, 2, 16'h0001, 1);
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 0, 16'h0000, (i % 4) == 1);
        cyc(0, 0, 2, 9, 16'h0000, 0);

        // Reset mid-sweep at cnt = 10, asserted between edges
        cyc(0, 1, 4, 4, 16'h4444, 0);
        cyc(0, 0, 0, 0, 16'h0000, 1);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 16'h0000, 0);
        #3 rst = 1'b1;
        #1;
        chk("async_ready0", {31'd0, ready0}, 32'd0);
        chk("async_ready1", {31'd0, ready1}, 32'd0);
        chk("async_out0",   {16'd0, out0 | out_b0}, 32'd0);
        chk("async_out1",   {16'd0, out1 | out_b1}, 32'd0);
        cyc(1, 0, 0, 0, 16'h0000, 0);
        for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 4, 4, 16'h0000, 0);

        // Randomised traffic with occasional clear requests
        for (int i = 0; i < 400; i++) begin
            cyc(0, 1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom),
                W'($urandom), ($urandom_range(0, 99) == 0));
        end

        @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
